// File: rtl/median_pkg.sv
// median_pkg: shared widths, pixel layout and position flags for the median filter datapath
package median_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 11;
    localparam int IMG_W  = 1024;

    // 8-bit channels packed R[23:16] G[15:8] B[7:0]
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Position of an output column inside the frame
    typedef struct packed {
        logic [ADDR_W-1:0] x;
        logic              sol;
        logic              eol;
        logic              rows_ok;
    } pos_t;

endpackage

// File: rtl/line_buffer_if.sv
// line_buffer_if: pixel stream in, aligned 3-row column plus position flags out
interface line_buffer_if #(
    parameter int DATA_W = median_pkg::DATA_W,
    parameter int ADDR_W = median_pkg::ADDR_W
);

    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_top;
    logic [DATA_W-1:0] out_mid;
    logic [DATA_W-1:0] out_bot;
    logic [ADDR_W-1:0] out_x;
    logic              out_sol;
    logic              out_eol;
    logic              out_rows_ok;

    // Upstream source: drives the pixel stream, observes the columns
    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_top, out_mid, out_bot, out_x, out_sol, out_eol, out_rows_ok
    );

    // Line buffer: consumes the pixel stream, produces the columns
    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_top, out_mid, out_bot, out_x, out_sol, out_eol, out_rows_ok
    );

endinterface

// File: rtl/bram.sv
// bram: single-port read-first block RAM with a one-cycle registered read
module bram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;

    // Storage array; contents survive reset by design
    always_ff @(posedge clk) begin
        if (en_i && we_i) mem_q[addr_i] <= din_i;
    end

    // Read-first port: the old word is returned even when writing the same address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else if (en_i) dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/line_buffer.sv
// line_buffer: two chained line RAMs turn a raster stream into aligned (y-2, y-1, y) columns
module line_buffer #(
    parameter int DATA_W = median_pkg::DATA_W,
    parameter int ADDR_W = median_pkg::ADDR_W,
    parameter int IMG_W  = median_pkg::IMG_W
) (
    input  logic          clk,
    input  logic          rst_n,
    line_buffer_if.slave  lb
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] x;
        logic              sol;
        logic              eol;
        logic              rows_ok;
    } flags_t;

    logic [ADDR_W-1:0] col_q, col_d, x_cur;
    logic [1:0]        row_q, row_d, y_cur;
    logic              last;
    flags_t            f_cur, f1_q, f2_q;
    logic              v1_q, v2_q;
    logic [DATA_W-1:0] bot1_q, bot2_q, mid2_q;
    logic [DATA_W-1:0] ram0_dout, ram1_dout;

    // Position of the incoming pixel; sof forces (0,0) and beats a row wrap
    always_comb begin
        x_cur = lb.in_sof ? '0 : col_q;
        y_cur = lb.in_sof ? 2'd0 : row_q;
        last  = (x_cur == LAST);
        col_d = !lb.in_valid ? col_q : last ? '0 : x_cur + 1'b1;
        row_d = !lb.in_valid ? row_q : !last ? y_cur : (y_cur == 2'd2) ? 2'd2 : y_cur + 2'd1;
        f_cur = '{x: x_cur, sol: (x_cur == '0), eol: last, rows_ok: (y_cur == 2'd2)};
    end

    // Column/row counters; row saturates at 2 so rows_ok holds until the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= 2'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // First line delay: returns the previous row's pixel at this x
    bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (lb.in_valid),
        .we_i   (lb.in_valid),
        .addr_i (x_cur),
        .din_i  (lb.in_data),
        .dout_o (ram0_dout)
    );

    // Second line delay: fed by the first, returns the pixel two rows up
    bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (v1_q),
        .we_i   (v1_q),
        .addr_i (f1_q.x),
        .din_i  (ram0_dout),
        .dout_o (ram1_dout)
    );

    // Two-stage delay keeping bottom pixel, mid pixel and flags aligned with the RAM reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            bot1_q <= '0;
            bot2_q <= '0;
            mid2_q <= '0;
            f1_q   <= '0;
            f2_q   <= '0;
        end else begin
            v1_q <= lb.in_valid;
            v2_q <= v1_q;
            if (lb.in_valid) begin
                bot1_q <= lb.in_data;
                f1_q   <= f_cur;
            end
            if (v1_q) begin
                bot2_q <= bot1_q;
                mid2_q <= ram0_dout;
                f2_q   <= f1_q;
            end
        end
    end

    assign lb.out_valid   = v2_q;
    assign lb.out_top     = ram1_dout;
    assign lb.out_mid     = mid2_q;
    assign lb.out_bot     = bot2_q;
    assign lb.out_x       = f2_q.x;
    assign lb.out_sol     = f2_q.sol;
    assign lb.out_eol     = f2_q.eol;
    assign lb.out_rows_ok = f2_q.rows_ok;

endmodule
